snn_if_layer: RTL and testbench
===============================

Name: snn_if_layer

Overview:
- Parametrised fully-connected layer of integrate-and-fire neurons: N_IN input spike lines feed N_OUT neurons through a run-time-writable signed weight matrix.
- Adds per-neuron threshold firing, refractory period, potential clamping and a priority-encoded winner output.
- Used as the building block for multi-layer SNN pipelines: a layer's fire vector drives the next layer's in_spike.

Parameters:
- N_IN, 3, number of input spike lines
- N_OUT, 3, number of neurons
- W_WIDTH, 4, signed weight width (two's complement)
- POT_WIDTH, 8, unsigned membrane potential width
- THRESHOLD, 4, fire when potential >= THRESHOLD (must be >=1 and < 2^POT_WIDTH)
- REFRAC, 2, steps ignored after a fire (0 = none)
- W_INIT, 1, value loaded into every weight on reset
- LEAK, 1, per-step decrement (used only with SNN_LEAK_EN)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- step_en  in  1  advance one time step this cycle
- in_spike  in  N_IN  input spikes, sampled when step_en=1
- wr_en  in  1  weight write strobe
- wr_in  in  clog2(N_IN)  weight row (source input)
- wr_out  in  clog2(N_OUT)  weight column (target neuron)
- wr_data  in  W_WIDTH  signed weight value
- fire  out  N_OUT  registered fire vector, one bit per neuron
- out_valid  out  1  pulses 1 cycle after each step_en
- out_idx  out  clog2(N_OUT+1)  1 + index of lowest-numbered firing neuron, 0 if none

Behaviour:
- Reset (reset=0, async): all potentials 0, refractory counters 0, fire=0, out_valid=0, out_idx=0, every weight = W_INIT. Reset mid-step discards that step.
- Cycles with step_en=0: potentials, counters and weights hold (except writes); fire, out_valid, out_idx driven 0.
- Step (step_en=1), per neuron j, result registered at the same edge:
  - If refrac[j]>0: refrac[j]-=1; potential held; fire[j]=0.
  - Else sum = pot[j] + Σ_i in_spike[i]·w[i][j], in signed arithmetic at width POT_WIDTH+W_WIDTH+clog2(N_IN)+1; clamp to [0, 2^POT_WIDTH-1].
  - If clamped sum >= THRESHOLD: fire[j]=1, pot[j]=0, refrac[j]=REFRAC. Otherwise pot[j]=clamped sum, fire[j]=0.
- Latency: fire/out_idx/out_valid valid on the cycle after step_en; out_valid=1 for exactly that cycle.
- out_idx: lowest j with fire[j]=1 gives j+1; ties resolved to lowest index.
- Weight write: on wr_en=1, w[wr_in][wr_out] <= wr_data at the clock edge. A step in the same cycle uses the old weight. Out-of-range wr_in/wr_out: write ignored.
- Back-to-back step_en every cycle is supported with no bubbles.

Optional Feature:
- Macro SNN_LEAK_EN.
- Defined: on each non-refractory step, pot[j] is reduced by LEAK (floored at 0) before the weighted sum is added.
- Undefined: no leak; the LEAK parameter is ignored.

Decomposition:
- Shared package snn_pkg holds the clamp/saturation function, the sum-width constant function and the default THRESHOLD/REFRAC/W_INIT constants.
- Sub-module snn_if_neuron (one neuron: potential, refractory counter, threshold compare) is instantiated N_OUT times.
- Weight RAM, weighted sum and priority encoder stay in snn_if_layer.

Test Plan:
- Defaults, in_spike=111, step every cycle: all potentials 3 after step 1; step 2 gives fire=111, out_idx=1; steps 3-4 show fire=000 (refractory); step 6 fires again.
- Write w[1][2]=3, then step with in_spike=010 twice: step 2 gives fire=100, out_idx=3; pot[0]=pot[1]=2.
- Write w[0][0]=-8, in_spike=001 for 5 steps: pot[0] stays 0, fire[0] never set; the other neurons fire on step 4 (see the leak case for the leak variant).
- Same cycle wr_en (w[0][1]=3) and step with in_spike=001: that step adds 1 to pot[1]; the next step adds 3.
- Reset asserted mid-run with pot=3: fire=0, out_valid=0 immediately; after release one step with in_spike=111 gives pot=3 (weights back to 1).
- SNN_LEAK_EN, LEAK=1, in_spike=001 on alternate steps: pot[0] sequence 1,0,1,0…; fire never set.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared constants and arithmetic helpers for the integrate-and-fire layer.
// Build option: SNN_LEAK_EN enables the per-step potential leak in snn_if_neuron.
package snn_pkg;

  localparam int DEF_THRESHOLD = 4;
  localparam int DEF_REFRAC    = 2;
  localparam int DEF_W_INIT    = 1;

  // Width that holds pot + N_IN signed weights with no overflow.
  function automatic int sum_width(input int pot_w, input int w_w, input int n_in);
    return pot_w + w_w + $clog2(n_in) + 1;
  endfunction

  // Saturate a signed sum into the unsigned range [0, 2^pot_w-1].
  function automatic logic [31:0] sat_clamp(input logic signed [31:0] v, input int pot_w);
    logic signed [31:0] max_v;
    max_v = (32'sd1 <<< pot_w) - 32'sd1;
    if (v < 32'sd0)
      return '0;
    else if (v > max_v)
      return max_v;
    else
      return v;
  endfunction

endpackage

// File: rtl/snn_if_neuron.sv
// One integrate-and-fire neuron: membrane potential, refractory counter, threshold compare.
// Build option: SNN_LEAK_EN subtracts LEAK (floored at 0) before integration.
module snn_if_neuron
  import snn_pkg::*;
#(
  parameter int POT_WIDTH = 8,
  parameter int SUM_W     = 15,
  parameter int THRESHOLD = DEF_THRESHOLD,
  parameter int REFRAC    = DEF_REFRAC,
  parameter int LEAK      = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    step_en,
  input  logic signed [SUM_W-1:0] syn_sum,
  output logic                    fire_next
);

  localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
`ifdef SNN_LEAK_EN
  localparam int LEAK_EFF = LEAK;
`else
  // LEAK has no effect in this build.
  localparam int LEAK_EFF = 0 * LEAK;
`endif

  logic [POT_WIDTH-1:0]    pot_q, pot_d;
  logic [RW-1:0]           refrac_q, refrac_d;
  logic [POT_WIDTH-1:0]    leaked;
  logic signed [SUM_W-1:0] total;
  logic [POT_WIDTH-1:0]    clamped;

  always_comb begin
    pot_d     = pot_q;
    refrac_d  = refrac_q;
    fire_next = 1'b0;
    leaked    = (pot_q > POT_WIDTH'(LEAK_EFF)) ? pot_q - POT_WIDTH'(LEAK_EFF) : '0;
    total     = $signed({{(SUM_W-POT_WIDTH){1'b0}}, leaked}) + syn_sum;
    clamped   = POT_WIDTH'(sat_clamp(32'(total), POT_WIDTH));
    if (step_en) begin
      if (refrac_q != '0) begin
        refrac_d = refrac_q - 1'b1;
      end else if (clamped >= POT_WIDTH'(THRESHOLD)) begin
        fire_next = 1'b1;
        pot_d     = '0;
        refrac_d  = RW'(REFRAC);
      end else begin
        pot_d = clamped;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pot_q    <= '0;
      refrac_q <= '0;
    end else begin
      pot_q    <= pot_d;
      refrac_q <= refrac_d;
    end
  end

endmodule

// File: rtl/snn_if_layer.sv
// Fully-connected integrate-and-fire layer: writable weight matrix, per-neuron IF cells, winner index.
// Build option: SNN_LEAK_EN (passed through to every snn_if_neuron).
module snn_if_layer
  import snn_pkg::*;
#(
  parameter int N_IN      = 3,
  parameter int N_OUT     = 3,
  parameter int W_WIDTH   = 4,
  parameter int POT_WIDTH = 8,
  parameter int THRESHOLD = DEF_THRESHOLD,
  parameter int REFRAC    = DEF_REFRAC,
  parameter int W_INIT    = DEF_W_INIT,
  parameter int LEAK      = 1,
  localparam int IN_AW    = (N_IN > 1) ? $clog2(N_IN) : 1,
  localparam int OUT_AW   = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  localparam int IDX_W    = $clog2(N_OUT + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      step_en,
  input  logic [N_IN-1:0]           in_spike,
  input  logic                      wr_en,
  input  logic [IN_AW-1:0]          wr_in,
  input  logic [OUT_AW-1:0]         wr_out,
  input  logic signed [W_WIDTH-1:0] wr_data,
  output logic [N_OUT-1:0]          fire,
  output logic                      out_valid,
  output logic [IDX_W-1:0]          out_idx
);

  localparam int SUM_W = sum_width(POT_WIDTH, W_WIDTH, N_IN);

  logic signed [W_WIDTH-1:0] w_q [N_IN][N_OUT];
  logic signed [W_WIDTH-1:0] w_d [N_IN][N_OUT];
  logic [N_OUT-1:0]          fire_next;
  logic [N_OUT-1:0]          fire_q, fire_d;
  logic                      out_valid_q, out_valid_d;
  logic [IDX_W-1:0]          out_idx_q, out_idx_d;

  // Steps read w_q, so a write in the same cycle only affects later steps.
  always_comb begin
    w_d = w_q;
    if (wr_en && (int'(wr_in) < N_IN) && (int'(wr_out) < N_OUT))
      w_d[wr_in][wr_out] = wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_IN; i++)
        for (int j = 0; j < N_OUT; j++)
          w_q[i][j] <= W_WIDTH'(W_INIT);
    end else begin
      w_q <= w_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_neuron
      logic signed [SUM_W-1:0] syn_sum;

      always_comb begin
        syn_sum = '0;
        for (int i = 0; i < N_IN; i++)
          if (in_spike[i])
            syn_sum = syn_sum + SUM_W'(w_q[i][gi]);
      end

      snn_if_neuron #(
        .POT_WIDTH (POT_WIDTH),
        .SUM_W     (SUM_W),
        .THRESHOLD (THRESHOLD),
        .REFRAC    (REFRAC),
        .LEAK      (LEAK)
      ) u_neuron (
        .clk       (clk),
        .reset     (reset),
        .step_en   (step_en),
        .syn_sum   (syn_sum),
        .fire_next (fire_next[gi])
      );
    end
  endgenerate

  // Scan from the top so the lowest firing index wins.
  always_comb begin
    out_idx_d = '0;
    for (int j = N_OUT - 1; j >= 0; j--)
      if (fire_next[j])
        out_idx_d = IDX_W'(j + 1);
    fire_d      = fire_next;
    out_valid_d = step_en;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fire_q      <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
    end else begin
      fire_q      <= fire_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
    end
  end

  assign fire      = fire_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_snn_if_layer.sv
// Directed self-checking bench for snn_if_layer with default parameters.
// Build option: SNN_LEAK_EN switches the leak-dependent expectations and adds the leak sequence.
module tb_snn_if_layer;

`ifdef SNN_LEAK_EN
  localparam bit LEAK_ON = 1'b1;
`else
  localparam bit LEAK_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              step_en;
  logic [2:0]        in_spike;
  logic              wr_en;
  logic [1:0]        wr_in;
  logic [1:0]        wr_out;
  logic signed [3:0] wr_data;
  logic [2:0]        fire;
  logic              out_valid;
  logic [1:0]        out_idx;

  int checks = 0;
  int errors = 0;

  snn_if_layer dut (
    .clk       (clk),
    .reset     (reset),
    .step_en   (step_en),
    .in_spike  (in_spike),
    .wr_en     (wr_en),
    .wr_in     (wr_in),
    .wr_out    (wr_out),
    .wr_data   (wr_data),
    .fire      (fire),
    .out_valid (out_valid),
    .out_idx   (out_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
    $display("check %-16s observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    step_en = 1'b0;
    wr_en   = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic step(input logic [2:0] spk);
    step_en  = 1'b1;
    in_spike = spk;
    @(posedge clk); #1;
    step_en = 1'b0;
  endtask

  task automatic wr(input int i, input int o, input int d);
    wr_en   = 1'b1;
    wr_in   = 2'(i);
    wr_out  = 2'(o);
    wr_data = 4'(d);
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; step_en = 1'b0; in_spike = '0;
    wr_en = 1'b0; wr_in = '0; wr_out = '0; wr_data = '0;
    #12;
    chk("rst_fire", fire, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_pot0", dut.g_neuron[0].u_neuron.pot_q, 0);

    // All inputs active, step every cycle
    do_reset();
    step(3'b111);
    chk("t1_s1_fire", fire, 0);
    chk("t1_s1_valid", out_valid, 1);
    chk("t1_s1_pot0", dut.g_neuron[0].u_neuron.pot_q, 3);
    chk("t1_s1_pot2", dut.g_neuron[2].u_neuron.pot_q, 3);
    step(3'b111);
    chk("t1_s2_fire", fire, 3'b111);
    chk("t1_s2_idx", out_idx, 1);
    chk("t1_s2_pot1", dut.g_neuron[1].u_neuron.pot_q, 0);
    step(3'b111);
    chk("t1_s3_fire", fire, 0);
    chk("t1_s3_valid", out_valid, 1);
    step(3'b111);
    chk("t1_s4_fire", fire, 0);
    step(3'b111);
    chk("t1_s5_fire", fire, 0);
    chk("t1_s5_pot1", dut.g_neuron[1].u_neuron.pot_q, 3);
    step(3'b111);
    chk("t1_s6_fire", fire, 3'b111);
    chk("t1_s6_idx", out_idx, 1);
    @(posedge clk); #1;
    chk("t1_idle_valid", out_valid, 0);
    chk("t1_idle_fire", fire, 0);
    chk("t1_idle_idx", out_idx, 0);

    // Heavier weight on neuron 2 from input 1
    do_reset();
    wr(1, 2, 3);
    step(3'b010);
    chk("t2_s1_pot2", dut.g_neuron[2].u_neuron.pot_q, 3);
    chk("t2_s1_fire", fire, 0);
    step(3'b010);
    chk("t2_s2_fire", fire, 3'b100);
    chk("t2_s2_idx", out_idx, 3);
    chk("t2_s2_pot0", dut.g_neuron[0].u_neuron.pot_q, LEAK_ON ? 1 : 2);
    chk("t2_s2_pot1", dut.g_neuron[1].u_neuron.pot_q, LEAK_ON ? 1 : 2);

    // Strongly negative weight clamps at zero
    do_reset();
    wr(0, 0, -8);
    step(3'b001);
    chk("t3_s1_fire", fire, 0);
    chk("t3_s1_pot0", dut.g_neuron[0].u_neuron.pot_q, 0);
    step(3'b001);
    chk("t3_s2_fire", fire, 0);
    step(3'b001);
    chk("t3_s3_fire", fire, 0);
    step(3'b001);
    chk("t3_s4_fire", fire, LEAK_ON ? 3'b000 : 3'b110);
    chk("t3_s4_idx", out_idx, LEAK_ON ? 0 : 2);
    step(3'b001);
    chk("t3_s5_fire", fire, 0);
    chk("t3_s5_pot0", dut.g_neuron[0].u_neuron.pot_q, 0);

    // Write and step in the same cycle: step sees the old weight
    do_reset();
    step_en = 1'b1; in_spike = 3'b001;
    wr_en = 1'b1; wr_in = 2'd0; wr_out = 2'd1; wr_data = 4'sd3;
    @(posedge clk); #1;
    step_en = 1'b0; wr_en = 1'b0;
    chk("t4_s1_pot1", dut.g_neuron[1].u_neuron.pot_q, 1);
    step(3'b001);
    chk("t4_s2_fire", fire, LEAK_ON ? 3'b000 : 3'b010);
    chk("t4_s2_idx", out_idx, LEAK_ON ? 0 : 2);
    chk("t4_s2_pot1", dut.g_neuron[1].u_neuron.pot_q, LEAK_ON ? 3 : 0);

    // Asynchronous reset in the middle of a step
    do_reset();
    wr(0, 0, -8);
    step(3'b111);
    chk("t5_pre_pot1", dut.g_neuron[1].u_neuron.pot_q, 3);
    chk("t5_pre_pot0", dut.g_neuron[0].u_neuron.pot_q, 0);
    step_en = 1'b1; in_spike = 3'b111;
    #2 reset = 1'b0;
    #1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_fire", fire, 0);
    chk("t5_rst_pot1", dut.g_neuron[1].u_neuron.pot_q, 0);
    step_en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    step(3'b111);
    chk("t5_post_pot0", dut.g_neuron[0].u_neuron.pot_q, 3);
    chk("t5_post_pot2", dut.g_neuron[2].u_neuron.pot_q, 3);
    chk("t5_post_valid", out_valid, 1);
    chk("t5_post_fire", fire, 0);

`ifdef SNN_LEAK_EN
    // Leak: alternating single spikes never accumulate
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step((k % 2 == 0) ? 3'b001 : 3'b000);
      chk("t6_pot0", dut.g_neuron[0].u_neuron.pot_q, (k % 2 == 0) ? 1 : 0);
      chk("t6_fire", fire, 0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
